// File: rtl/rk_sdram_arbiter.sv
// rk_sdram_arbiter: one-access-at-a-time SDRAM port scheduler for video DMA reads and CPU accesses,
// video first with a CPU anti-starvation limit; every output is registered.
module rk_sdram_arbiter #(
    parameter int ACC_CYCLES = 6,
    parameter int MAX_VID    = 4,
    parameter int ADDR_W     = 15
) (
    input  logic              clk50mhz,
    input  logic              reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [7:0]        i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [7:0]        o_cpu_rdata,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_ack,
    output logic [7:0]        o_vid_rdata,
    output logic [17:0]       o_mem_addr,
    output logic [7:0]        o_mem_idata,
    output logic              o_mem_rd,
    output logic              o_mem_we_n,
    input  logic [15:0]       i_mem_odata,
    output logic              o_busy
);
    localparam int CW = $clog2(ACC_CYCLES);
    localparam int SW = $clog2(MAX_VID + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [SW-1:0]   r_streak, w_streak;
    logic            r_sel_vid, w_sel_vid;
    logic [17:0]     r_mem_addr, w_mem_addr;
    logic [7:0]      r_mem_idata, w_mem_idata;
    logic            r_mem_rd, w_mem_rd;
    logic            r_mem_we_n, w_mem_we_n;
    logic            r_cpu_ack, w_cpu_ack;
    logic            r_vid_ack, w_vid_ack;
    logic [7:0]      r_cpu_rdata, w_cpu_rdata;
    logic [7:0]      r_vid_rdata, w_vid_rdata;
    logic            r_busy, w_busy;
    logic            w_vid_win;
    logic            w_unused_odata;

    assign w_unused_odata = ^i_mem_odata[15:8];

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_streak    = r_streak;
        w_sel_vid   = r_sel_vid;
        w_mem_addr  = r_mem_addr;
        w_mem_idata = r_mem_idata;
        w_mem_rd    = r_mem_rd;
        w_mem_we_n  = r_mem_we_n;
        w_cpu_ack   = 1'b0;
        w_vid_ack   = 1'b0;
        w_cpu_rdata = r_cpu_rdata;
        w_vid_rdata = r_vid_rdata;
        w_busy      = r_busy;
        w_vid_win   = i_vid_req & (~i_cpu_req | (r_streak < SW'(MAX_VID)));
        unique case (r_state)
            IDLE: begin
                if (w_vid_win) begin
                    w_state    = ACCESS;
                    w_cnt      = CW'(ACC_CYCLES - 1);
                    w_sel_vid  = 1'b1;
                    w_mem_addr = {{(18-ADDR_W){1'b0}}, i_vid_addr};
                    w_mem_rd   = 1'b1;
                    w_mem_we_n = 1'b1;
                    w_busy     = 1'b1;
                    // streak only grows while the CPU is actually being held off
                    w_streak   = ~i_cpu_req ? '0 :
                                 (r_streak == SW'(MAX_VID)) ? r_streak : r_streak + SW'(1);
                end else if (i_cpu_req) begin
                    w_state     = ACCESS;
                    w_cnt       = CW'(ACC_CYCLES - 1);
                    w_sel_vid   = 1'b0;
                    w_mem_addr  = {{(18-ADDR_W){1'b0}}, i_cpu_addr};
                    w_mem_idata = i_cpu_we ? i_cpu_wdata : r_mem_idata;
                    w_mem_rd    = ~i_cpu_we;
                    w_mem_we_n  = ~i_cpu_we;
                    w_busy      = 1'b1;
                    w_streak    = '0;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state     = RECOVER;
                    w_mem_rd    = 1'b0;
                    w_mem_we_n  = 1'b1;
                    w_vid_ack   = r_sel_vid;
                    w_cpu_ack   = ~r_sel_vid;
                    w_vid_rdata = r_sel_vid ? i_mem_odata[7:0] : r_vid_rdata;
                    w_cpu_rdata = (~r_sel_vid & r_mem_we_n) ? i_mem_odata[7:0] : r_cpu_rdata;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            RECOVER: begin
                w_state = IDLE;
                w_busy  = 1'b0;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_sel_vid   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_idata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_we_n  <= 1'b1;
            r_cpu_ack   <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_streak    <= w_streak;
            r_sel_vid   <= w_sel_vid;
            r_mem_addr  <= w_mem_addr;
            r_mem_idata <= w_mem_idata;
            r_mem_rd    <= w_mem_rd;
            r_mem_we_n  <= w_mem_we_n;
            r_cpu_ack   <= w_cpu_ack;
            r_vid_ack   <= w_vid_ack;
            r_cpu_rdata <= w_cpu_rdata;
            r_vid_rdata <= w_vid_rdata;
            r_busy      <= w_busy;
        end
    end

    assign o_cpu_ack   = r_cpu_ack;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_vid_ack   = r_vid_ack;
    assign o_vid_rdata = r_vid_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_idata = r_mem_idata;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_we_n  = r_mem_we_n;
    assign o_busy      = r_busy;
endmodule
